// File: rtl/rx_cmd_decoder.sv
// rx_cmd_decoder: turns the UART receiver's byte stream into register-file
// writes and reads, ALU operand loads and ALU function strobes.
// Frames:
//   AA addr data    register write
//   BB addr         register read
//   CC opA opB fun  load both operands into registers 0/1, then run the ALU
//   DD fun          run the ALU
// Every output is registered, so a strobe appears in the cycle after the byte
// that caused it was accepted.
module rx_cmd_decoder #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic                  RX_ERR,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] WrData,
  output logic                  ALU_EN,
  output logic [3:0]            ALU_FUN,
  output logic                  CLK_GATE_EN,
  output logic                  CMD_ERR
);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    OP_A,
    OP_B,
    ALU_FUN_S
  } state_t;

  localparam logic [DATA_WIDTH-1:0] CMD_WR  = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD  = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_OPS = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_FUN = DATA_WIDTH'(8'hDD);
  localparam logic [15:0]           TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t                state, state_next;
  logic [15:0]           idle_cnt, idle_cnt_next;
  logic [ADDR_WIDTH-1:0] addr_hold, addr_hold_next;

  logic                  wr_en_next, rd_en_next, alu_en_next;
  logic                  cmd_err_next, gate_next;
  logic [ADDR_WIDTH-1:0] address_next;
  logic [DATA_WIDTH-1:0] wr_data_next;
  logic [3:0]            alu_fun_next;

  logic accept;
  logic discard;
  logic addr_ok;
  logic timeout;

  assign accept  = RX_D_VLD && !RX_ERR;
  assign discard = RX_D_VLD && RX_ERR;
  // Register addresses arrive in a full byte; any bit above the address
  // range marks the frame as malformed.
  assign addr_ok = (RX_P_DATA[DATA_WIDTH-1:ADDR_WIDTH] == '0);
  assign timeout = (state != IDLE) && (idle_cnt == TIMEOUT_LAST);

  // Next state, idle counter and next output values.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_next     = state;
    idle_cnt_next  = (state == IDLE) ? 16'd0 : idle_cnt + 16'd1;
    addr_hold_next = addr_hold;
    wr_en_next     = 1'b0;
    rd_en_next     = 1'b0;
    alu_en_next    = 1'b0;
    cmd_err_next   = 1'b0;
    address_next   = Address;
    wr_data_next   = WrData;
    alu_fun_next   = ALU_FUN;

    if (accept) begin
      idle_cnt_next = 16'd0;
      unique case (state)
        IDLE: begin
          if      (RX_P_DATA == CMD_WR)  state_next = WR_ADDR;
          else if (RX_P_DATA == CMD_RD)  state_next = RD_ADDR;
          else if (RX_P_DATA == CMD_OPS) state_next = OP_A;
          else if (RX_P_DATA == CMD_FUN) state_next = ALU_FUN_S;
          else                           cmd_err_next = 1'b1;
        end
        WR_ADDR: begin
          if (addr_ok) begin
            addr_hold_next = RX_P_DATA[ADDR_WIDTH-1:0];
            state_next     = WR_DATA;
          end else begin
            cmd_err_next = 1'b1;
            state_next   = IDLE;
          end
        end
        WR_DATA: begin
          wr_en_next   = 1'b1;
          address_next = addr_hold;
          wr_data_next = RX_P_DATA;
          state_next   = IDLE;
        end
        RD_ADDR: begin
          if (addr_ok) begin
            rd_en_next   = 1'b1;
            address_next = RX_P_DATA[ADDR_WIDTH-1:0];
          end else begin
            cmd_err_next = 1'b1;
          end
          state_next = IDLE;
        end
        OP_A: begin
          wr_en_next   = 1'b1;
          address_next = '0;
          wr_data_next = RX_P_DATA;
          state_next   = OP_B;
        end
        OP_B: begin
          wr_en_next   = 1'b1;
          address_next = ADDR_WIDTH'(1);
          wr_data_next = RX_P_DATA;
          state_next   = ALU_FUN_S;
        end
        ALU_FUN_S: begin
          alu_en_next  = 1'b1;
          alu_fun_next = RX_P_DATA[3:0];
          state_next   = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end else if (state != IDLE && (discard || timeout)) begin
      // A corrupted byte or a stalled sender abandons the frame in progress;
      // a byte accepted in the timeout cycle takes the branch above instead.
      cmd_err_next  = 1'b1;
      state_next    = IDLE;
      idle_cnt_next = 16'd0;
    end

    // The ALU clock runs while an ALU frame is open and through its ALU_EN
    // cycle; an aborted frame lands in IDLE and so drops it with CMD_ERR.
    gate_next = alu_en_next ||
                (state_next == OP_A) || (state_next == OP_B) ||
                (state_next == ALU_FUN_S);
  end

  // FSM state, idle counter and latched write address.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the values from before this edge.
      state     <= IDLE;
      idle_cnt  <= 16'd0;
      addr_hold <= '0;
    end else begin
      state     <= state_next;
      idle_cnt  <= idle_cnt_next;
      addr_hold <= addr_hold_next;
    end
  end

  // Registered outputs; strobes last one cycle, data outputs hold otherwise.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      WrEn        <= 1'b0;
      RdEn        <= 1'b0;
      ALU_EN      <= 1'b0;
      CMD_ERR     <= 1'b0;
      CLK_GATE_EN <= 1'b0;
      Address     <= '0;
      WrData      <= '0;
      ALU_FUN     <= 4'd0;
    end else begin
      WrEn        <= wr_en_next;
      RdEn        <= rd_en_next;
      ALU_EN      <= alu_en_next;
      CMD_ERR     <= cmd_err_next;
      CLK_GATE_EN <= gate_next;
      Address     <= address_next;
      WrData      <= wr_data_next;
      ALU_FUN     <= alu_fun_next;
    end
  end

endmodule

// File: doc/rx_cmd_decoder.md
RX_CMD_DECODER -- requirements
Module: rx_cmd_decoder

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of the received byte and of the register write data.
REQ-002 Parameter ADDR_WIDTH, default 4, register-file address width.
REQ-003 Parameter TIMEOUT_CYCLES, default 50000, maximum number of idle cycles allowed between bytes of one frame.
REQ-004 CLK  input  1  single clock; all state changes on the rising edge.
REQ-005 RST  input  1  asynchronous, active-high reset.
REQ-006 RX_P_DATA  input  DATA_WIDTH  received byte from the UART receiver.
REQ-007 RX_D_VLD  input  1  one-cycle strobe qualifying RX_P_DATA.
REQ-008 RX_ERR  input  1  parity or stop error on the byte strobed in the same cycle.
REQ-009 WrEn  output  1  one-cycle register-file write strobe.
REQ-010 RdEn  output  1  one-cycle register-file read strobe.
REQ-011 Address  output  ADDR_WIDTH  register-file address, valid while WrEn or RdEn is high.
REQ-012 WrData  output  DATA_WIDTH  write data, valid while WrEn is high.
REQ-013 ALU_EN  output  1  one-cycle ALU operation strobe.
REQ-014 ALU_FUN  output  4  ALU function code, valid while ALU_EN is high.
REQ-015 CLK_GATE_EN  output  1  ALU clock-gate enable.
REQ-016 CMD_ERR  output  1  one-cycle strobe flagging a frame abort or an unknown command.

Function
REQ-017 States SHALL be IDLE, WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, ALU_FUN_S.
- A byte is accepted in a cycle where RX_D_VLD=1 and RX_ERR=0.
- All outputs SHALL be registered.
- Any strobe SHALL appear exactly one cycle after the accepting cycle.
REQ-018 In IDLE, the accepted byte selects the next state:
- 0xAA -> WR_ADDR
- 0xBB -> RD_ADDR
- 0xCC -> OP_A
- 0xDD -> ALU_FUN_S
- any other value: stay in IDLE and pulse CMD_ERR.
REQ-019 WR_ADDR: the accepted byte's low ADDR_WIDTH bits SHALL be latched as the address; go to WR_DATA.
- If any upper bit is nonzero: pulse CMD_ERR and return to IDLE.
REQ-020 WR_DATA: the accepted byte SHALL produce a WrEn pulse with the latched Address and WrData=byte; return to IDLE.
REQ-021 RD_ADDR: the accepted byte SHALL pass the same address check as WR_ADDR.
- On pass: RdEn pulse with Address=byte[ADDR_WIDTH-1:0]; return to IDLE.
REQ-022 OP_A: the accepted byte SHALL produce a WrEn pulse with Address=0, WrData=byte; go to OP_B.
REQ-023 OP_B: the accepted byte SHALL produce a WrEn pulse with Address=1, WrData=byte; go to ALU_FUN_S.
REQ-024 ALU_FUN_S: the accepted byte SHALL produce an ALU_EN pulse with ALU_FUN=byte[3:0]; return to IDLE.
- Upper bits of the function byte are ignored.
REQ-025 CLK_GATE_EN SHALL be 1 from the cycle after entry into OP_A or ALU_FUN_S through the ALU_EN pulse cycle inclusive.
- It SHALL drop in the same cycle as CMD_ERR when a frame aborts.
REQ-026 RX_D_VLD=1 with RX_ERR=1 SHALL discard the byte.
- In IDLE: no other effect.
- In any other state: pulse CMD_ERR and return to IDLE.
REQ-027 A 16-bit idle counter SHALL clear on every accepted byte and in IDLE, and increment each cycle in any other state.
- On reaching TIMEOUT_CYCLES-1: pulse CMD_ERR, return to IDLE, clear the counter.
REQ-028 If a byte is accepted in the same cycle the timeout fires, the byte SHALL take priority and the timeout is cancelled.
REQ-029 At most one of WrEn, RdEn, ALU_EN SHALL be high in any cycle.
- Address, WrData and ALU_FUN SHALL hold their last values when no strobe is active.
REQ-030 Back-to-back strobes on consecutive cycles SHALL each be processed; no byte is dropped.

Reset
REQ-031 While RST=1, state SHALL be IDLE and the idle counter 0.
- Reset values: WrEn=0, RdEn=0, ALU_EN=0, CMD_ERR=0, CLK_GATE_EN=0, Address=0, WrData=0, ALU_FUN=0.
REQ-032 Reset asserted mid-frame SHALL abandon the frame with no strobe emitted, including a strobe due in the following cycle.

Verification
REQ-033 Bytes AA,05,3C -> one WrEn cycle with Address=5, WrData=0x3C, one cycle after the 3C strobe; CMD_ERR stays 0.
REQ-034 Bytes BB,0A -> one RdEn cycle with Address=0xA; bytes BB,1A -> CMD_ERR pulse, no RdEn, state IDLE.
REQ-035 Bytes CC,12,34,01 -> WrEn(0,0x12), then WrEn(1,0x34), then ALU_EN with ALU_FUN=1; CLK_GATE_EN high from after CC through the ALU_EN cycle.
REQ-036 Byte AA then no strobe for TIMEOUT_CYCLES cycles -> single CMD_ERR pulse, return to IDLE; a following AA,00,FF frame completes normally.
REQ-037 Byte CC, then byte 12 with RX_ERR=1 -> CMD_ERR pulse, CLK_GATE_EN drops, no WrEn; byte 7E in IDLE -> CMD_ERR only.
REQ-038 RST asserted one cycle after the final byte of AA,03,55 -> no WrEn; all outputs at reset values.
